// File: rtl/lcd_sequencer.sv
// HD44780 16x2 sequencer: power-up init, then full 32-char rewrites on request,
// driving the lcd_controller start/done handshake. Optional macro: LCD_AUTO_REFRESH_EN.
module lcd_sequencer #(
  parameter int unsigned POWERUP_CYCLES     = 750000,
  parameter int unsigned CMD_DELAY_CYCLES   = 2000,
  parameter int unsigned CLEAR_DELAY_CYCLES = 82000,
  parameter int unsigned REFRESH_CYCLES     = 5000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       refresh,
  output logic       busy,
  output logic       init_done,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic [7:0] ctrl_data,
  output logic       ctrl_rs,
  output logic       ctrl_start,
  input  logic       ctrl_done
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [CNT_W-1:0]  POWERUP_LIM = CNT_W'(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0]  CMD_LIM     = CNT_W'(CMD_DELAY_CYCLES);
  localparam logic [CNT_W-1:0]  CLEAR_LIM   = CNT_W'(CLEAR_DELAY_CYCLES);

  localparam logic [DATA_W-1:0] CMD_FUNC_SET = 8'h38;
  localparam logic [DATA_W-1:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [DATA_W-1:0] CMD_CLEAR    = 8'h01;
  localparam logic [DATA_W-1:0] CMD_ENTRY    = 8'h06;
  localparam logic [DATA_W-1:0] CMD_LINE0    = 8'h80;
  localparam logic [DATA_W-1:0] CMD_LINE1    = 8'hC0;

  localparam logic [ADDR_W-1:0] LINE0_LAST  = 5'd15;
  localparam logic [ADDR_W-1:0] LINE1_FIRST = 5'd16;
  localparam logic [ADDR_W-1:0] LINE1_LAST  = 5'd31;
  localparam logic [IDX_W-1:0]  INIT_LAST   = 2'd3;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_ADDR0,
    S_ADDR1,
    S_FETCH,
    S_CHARS,
    S_ISSUE,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_SETTLE
  } state_t;

  state_t              state, state_n;
  state_t              ret_state, ret_state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    init_idx, init_idx_n;
  logic                pending, pending_n;
  logic                init_done_n;
  logic [ADDR_W-1:0]   char_addr_n;
  logic [DATA_W-1:0]   ctrl_data_n;
  logic                ctrl_rs_n;
  logic                auto_tick;
  logic [DATA_W-1:0]   init_byte;
  logic [CNT_W-1:0]    delay_lim;
  logic                cnt_expired;

  // Init command table, indexed by position in the power-up sequence.
  always_comb begin
    init_byte = CMD_FUNC_SET;
    case (init_idx)
      2'd0:    init_byte = CMD_FUNC_SET;
      2'd1:    init_byte = CMD_DISP_ON;
      2'd2:    init_byte = CMD_CLEAR;
      default: init_byte = CMD_ENTRY;
    endcase
  end

  // Clear needs the long settle; everything else uses the short one.
  always_comb begin
    delay_lim = CMD_LIM;
    if (state == S_PWR_WAIT) begin
      delay_lim = POWERUP_LIM;
    end else if (!ctrl_rs && (ctrl_data == CMD_CLEAR)) begin
      delay_lim = CLEAR_LIM;
    end
  end

  // One bit wider so a limit of 2^24-1 still terminates; a limit of 0 gives one cycle.
  assign cnt_expired = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, delay_lim};

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned REF_W   = 32;
  localparam logic [REF_W-1:0] REFRESH_LIM = REF_W'(REFRESH_CYCLES);

  logic [REF_W-1:0] refresh_cnt;
  logic             refresh_wrap;

  assign refresh_wrap = ({1'b0, refresh_cnt} + (REF_W+1)'(1)) >= {1'b0, REFRESH_LIM};
  assign auto_tick    = init_done && refresh_wrap;

  // Free-running period counter, started by init completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
    end else if (init_done) begin
      if (refresh_wrap) begin
        refresh_cnt <= '0;
      end else begin
        refresh_cnt <= refresh_cnt + REF_W'(1);
      end
    end
  end
`else
  // Without auto-refresh the period parameter has no effect.
  assign auto_tick = (REFRESH_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_PWR_WAIT;
      ret_state  <= S_PWR_WAIT;
      cnt        <= '0;
      init_idx   <= '0;
      pending    <= 1'b0;
      init_done  <= 1'b0;
      char_addr  <= '0;
      ctrl_data  <= '0;
      ctrl_rs    <= 1'b0;
      ctrl_start <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      ret_state  <= ret_state_n;
      cnt        <= cnt_n;
      init_idx   <= init_idx_n;
      pending    <= pending_n;
      init_done  <= init_done_n;
      char_addr  <= char_addr_n;
      ctrl_data  <= ctrl_data_n;
      ctrl_rs    <= ctrl_rs_n;
      ctrl_start <= (state_n == S_ISSUE) || (state_n == S_WAIT_CLR) || (state_n == S_WAIT_DONE);
      busy       <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    ret_state_n = ret_state;
    cnt_n       = cnt;
    init_idx_n  = init_idx;
    pending_n   = pending || refresh || auto_tick;
    init_done_n = init_done;
    char_addr_n = char_addr;
    ctrl_data_n = ctrl_data;
    ctrl_rs_n   = ctrl_rs;

    case (state)
      S_PWR_WAIT: begin
        if (cnt_expired) begin
          cnt_n   = '0;
          state_n = S_INIT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_INIT: begin
        ctrl_data_n = init_byte;
        ctrl_rs_n   = 1'b0;
        ret_state_n = S_INIT;
        state_n     = S_ISSUE;
      end
      S_IDLE: begin
        if (pending) begin
          // A request seen on this very cycle still counts as a new one.
          pending_n = refresh || auto_tick;
          state_n   = S_ADDR0;
        end
      end
      S_ADDR0: begin
        ctrl_data_n = CMD_LINE0;
        ctrl_rs_n   = 1'b0;
        ret_state_n = S_ADDR0;
        state_n     = S_ISSUE;
      end
      S_ADDR1: begin
        ctrl_data_n = CMD_LINE1;
        ctrl_rs_n   = 1'b0;
        ret_state_n = S_ADDR1;
        state_n     = S_ISSUE;
      end
      S_FETCH: begin
        state_n = S_CHARS;
      end
      S_CHARS: begin
        ctrl_data_n = char_data;
        ctrl_rs_n   = 1'b1;
        ret_state_n = S_CHARS;
        state_n     = S_ISSUE;
      end
      S_ISSUE: begin
        state_n = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!ctrl_done) begin
          state_n = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (ctrl_done) begin
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!cnt_expired) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          cnt_n = '0;
          // Return to the caller and advance it past the byte just written.
          case (ret_state)
            S_INIT: begin
              if (init_idx == INIT_LAST) begin
                init_idx_n  = '0;
                init_done_n = 1'b1;
                state_n     = S_IDLE;
              end else begin
                init_idx_n = init_idx + IDX_W'(1);
                state_n    = S_INIT;
              end
            end
            S_ADDR0: begin
              char_addr_n = '0;
              state_n     = S_FETCH;
            end
            S_ADDR1: begin
              char_addr_n = LINE1_FIRST;
              state_n     = S_FETCH;
            end
            S_CHARS: begin
              char_addr_n = char_addr + ADDR_W'(1);
              if (char_addr == LINE0_LAST) begin
                state_n = S_ADDR1;
              end else if (char_addr == LINE1_LAST) begin
                state_n = S_IDLE;
              end else begin
                state_n = S_FETCH;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      default: state_n = S_PWR_WAIT;
    endcase
  end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Sits between the display buffer and `lcd_controller`, driving its host-side data/rs/start/done handshake.
- After reset it runs the HD44780 power-up init: wait, then function set, display on, clear, entry mode.
- On a refresh request it writes a 32-character buffer to the 16x2 display: set DDRAM address for line 0, write 16 chars, set address for line 1, write 16 chars.
- Between commands it inserts the controller-datasheet settle delays.

Parameters:
- POWERUP_CYCLES, 750000: clocks to wait after reset before the first command (15 ms at 50 MHz).
- CMD_DELAY_CYCLES, 2000: settle clocks after every command or char except clear (40 us).
- CLEAR_DELAY_CYCLES, 82000: settle clocks after the clear command 0x01 (1.64 ms).
- REFRESH_CYCLES, 5000000: auto-refresh period; used only with LCD_AUTO_REFRESH_EN.

Ports:
- clock, in, 1: system clock, same clock as `lcd_controller`.
- reset_n, in, 1: asynchronous active-low reset.
- refresh, in, 1: request a full 32-char rewrite; sampled every cycle, level or pulse.
- busy, out, 1: high whenever the sequencer is not in IDLE.
- init_done, out, 1: high once the init sequence has completed; stays high until reset.
- char_addr, out, 5: buffer read address; line 0 is 0-15, line 1 is 16-31.
- char_data, in, 8: buffer read data, valid one cycle after char_addr changes.
- ctrl_data, out, 8: to `lcd_controller` data.
- ctrl_rs, out, 1: to `lcd_controller` rs; 0 = command, 1 = character.
- ctrl_start, out, 1: to `lcd_controller` start (controller is rising-edge triggered).
- ctrl_done, in, 1: from `lcd_controller` done.

Behaviour:
- Reset values: busy=1, init_done=0, char_addr=0, ctrl_data=0x00, ctrl_rs=0, ctrl_start=0. Internal state is PWR_WAIT and counters are 0.
- Reset asserted mid-operation:
  - Aborts everything immediately and drops ctrl_start.
  - Discards any pending refresh.
  - Restarts from PWR_WAIT.
  - No partial-transfer recovery is required, because `lcd_controller` finishes any in-flight write well inside POWERUP_CYCLES.
- Main FSM:
  - PWR_WAIT: count POWERUP_CYCLES clocks, then go to INIT.
  - INIT: issue 0x38, 0x0C, 0x01, 0x06 in that order as commands (rs=0). After the last, set init_done=1 and go to IDLE.
  - IDLE: busy=0. If a refresh is pending, go to ADDR0.
  - ADDR0: issue command 0x80, then go to CHARS with char_addr=0.
  - CHARS: FETCH (drive char_addr, wait 1 cycle), then issue char_data as a character (rs=1), then increment char_addr.
    - After address 15, go to ADDR1.
    - After address 31, char_addr wraps to 0 and the FSM goes to IDLE.
  - ADDR1: issue command 0xC0, then resume CHARS at char_addr=16.
- Issue sub-sequence, identical for every byte:
  - ISSUE: latch ctrl_data/ctrl_rs; ctrl_start=1 for this cycle.
  - WAIT_CLR: hold ctrl_start=1 until ctrl_done==0. The controller clears done on the cycle after the rising edge.
  - WAIT_DONE: hold ctrl_start=1 until ctrl_done==1, then ctrl_start=0.
  - SETTLE: count CLEAR_DELAY_CYCLES if the byte was command 0x01, else CMD_DELAY_CYCLES, then return to the caller state.
  - ctrl_data/ctrl_rs are stable from ISSUE through the end of SETTLE.
  - ctrl_start is low for at least one cycle between consecutive issues.
- Refresh handling:
  - A pending flag is set on any cycle where refresh=1, including during PWR_WAIT, INIT or an active refresh.
  - The flag is cleared on the transition IDLE→ADDR0.
  - Effect: a request arriving during a refresh causes exactly one additional full refresh; multiple requests coalesce.
- A held ctrl_done=1 already in WAIT_CLR does not advance the FSM. The stale done from the previous transfer must first be seen low.
- No timeout on ctrl_done: a stuck controller holds the FSM in WAIT_CLR/WAIT_DONE with busy=1.
- Delay counter is 24 bits and compares with >= so that parameters up to 2^24-1 are legal. A parameter value of 0 gives a 1-cycle settle.

Optional Feature:
- Macro: LCD_AUTO_REFRESH_EN.
- When defined:
  - A free-running counter starts once init_done=1.
  - It sets the pending-refresh flag every REFRESH_CYCLES clocks.
  - Its wrap is treated exactly like refresh=1.
  - The counter resets with reset_n.
- When not defined: no counter is synthesised, and refreshes occur only via the refresh port.

Test Plan (sim params POWERUP=20, CMD=4, CLEAR=8, with a behavioural `lcd_controller` attached):
- Release reset, no refresh → ctrl_start first rises 20 cycles after reset release. Bytes 0x38, 0x0C, 0x01, 0x06 all have rs=0. The gap after 0x01 is longer than after 0x0C by 4 cycles. init_done=1 and busy=0 after 0x06 settles.
- Buffer holds 0x41+i at address i; pulse refresh once → byte stream is 0x80, 0x41..0x50, 0xC0, 0x51..0x60, with rs=0 only on 0x80/0xC0. Ends with busy=0 and char_addr=0.
- Pulse refresh during PWR_WAIT and twice during an active refresh → exactly two full 34-byte refreshes follow init, then idle.
- Assert reset_n low in the middle of the char at address 7 → all outputs take reset values asynchronously. After release, the full init sequence repeats and no refresh runs without a new request.
- Controller model keeps done=1 for 3 extra cycles before clearing → no double issue; ctrl_start stays high until the new done, and exactly one byte is written per issue.
- With LCD_AUTO_REFRESH_EN and REFRESH_CYCLES=300, no refresh input → refreshes begin every 300 cycles after init_done. Without the macro, no byte is written after init.
